// File: rtl/lsu_pkg.sv
// Types and constants shared by the LSU-side memory responder, its channel and its array.
package lsu_pkg;

  localparam logic [63:0] BASE_ADDR_DEFAULT = 64'h8000_0000;
  localparam int          MASK_W            = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [63:0]       addr;
    logic              wen;
    logic [63:0]       wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  // Unsigned window test: addresses below base never wrap into the window.
  function automatic logic in_window(logic [63:0] addr, logic [63:0] base, logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// Request/response channel between the LSU (master) and the memory responder (slave).
interface pmem_responder_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic              req_wen;
  logic [63:0]       req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/pmem_array.sv
// Single-port DEPTH x 64 word array with byte write enables and registered read data.
module pmem_array
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [63:0]              wdata,
  input  logic [MASK_W-1:0]        wmask,
  output logic [63:0]              rdata
);

  logic [63:0] mem [DEPTH];

  // Read data only moves on a load, so it stays put while a response is held.
  always_ff @(posedge clock) begin
    if (en) begin
      if (wen) begin
        for (int i = 0; i < MASK_W; i++) begin
          if (wmask[i]) begin
            mem[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Memory-side target of the LSU channel: one request at a time, fixed extra latency,
// backed by an on-chip word array.
module pmem_responder
  import lsu_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          LATENCY   = 2
) (
  input  logic             clock,
  input  logic             reset,
  pmem_responder_if.slave  bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        err_q, err_d;
  logic        mem_en;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [63:0] mem_rdata;

  assign in_range = in_window(req_q.addr, BASE_ADDR, SPAN);
  assign idx      = AW'((req_q.addr - BASE_ADDR) >> 3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // The array is touched only on the WAIT->RESP edge, so a reset during the wait drops the access.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    err_d          = err_q;
    mem_en         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          req_d.addr  = bus.req_addr;
          req_d.wen   = bus.req_wen;
          req_d.wdata = bus.req_wdata;
          req_d.wmask = bus.req_wmask;
          cnt_d       = 4'(LATENCY);
          err_d       = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_en  = in_range;
          err_d   = !in_range;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.resp_rdata = (state_q == RESP && !req_q.wen && !err_q) ? mem_rdata : 64'd0;
  assign bus.resp_err   = (state_q == RESP) && err_q;

  pmem_array #(.DEPTH(DEPTH)) u_array (
    .clock (clock),
    .en    (mem_en),
    .wen   (req_q.wen),
    .idx   (idx),
    .wdata (req_q.wdata),
    .wmask (req_q.wmask),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: a LATENCY=2 and a LATENCY=0 instance checked
// every cycle against a transaction-level memory model.
module tb_pmem_responder;
  import lsu_pkg::*;

  localparam int          DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pmem_responder_if bus_a();
  pmem_responder_if bus_b();

  pmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave)
  );
  pmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model state per lane: one outstanding request at most.
  int          lat [2] = '{2, 0};
  bit          pend [2];
  bit          done [2];
  int          acc [2];
  logic [63:0] p_addr [2];
  logic [63:0] p_wdata [2];
  logic        p_wen [2];
  logic [7:0]  p_wmask [2];
  logic [63:0] e_rdata [2];
  logic        e_err [2];
  logic [63:0] mdl [logic [64:0]];

  task automatic check_output(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void model_commit(int l);
    logic [64:0] key;
    logic [63:0] w;
    if (p_addr[l] < BASE || (p_addr[l] - BASE) >= SPAN) begin
      e_err[l]   = 1'b1;
      e_rdata[l] = 64'd0;
    end else begin
      key = {l[0], (p_addr[l] - BASE) >> 3};
      w   = mdl.exists(key) ? mdl[key] : 64'hx;
      e_err[l] = 1'b0;
      if (p_wen[l]) begin
        for (int b = 0; b < 8; b++)
          if (p_wmask[l][b]) w[8*b +: 8] = p_wdata[l][8*b +: 8];
        mdl[key]   = w;
        e_rdata[l] = 64'd0;
      end else begin
        e_rdata[l] = w;
      end
    end
  endfunction

  task automatic check_lane(int l, logic req_valid, logic req_ready, logic [63:0] req_addr,
                            logic req_wen, logic [63:0] req_wdata, logic [7:0] req_wmask,
                            logic resp_valid, logic resp_ready, logic [63:0] resp_rdata,
                            logic resp_err);
    bit    was_idle;
    string tag;
    was_idle = !pend[l];
    tag = $sformatf("lane%0d", l);
    if (pend[l] && !done[l] && cyc >= acc[l] + lat[l] + 2) begin
      model_commit(l);
      done[l] = 1'b1;
    end
    check_output({tag, "_req_ready"}, 64'(req_ready), 64'(was_idle));
    check_output({tag, "_resp_valid"}, 64'(resp_valid), 64'(pend[l] && done[l]));
    if (pend[l] && done[l]) begin
      check_output({tag, "_resp_rdata"}, resp_rdata, e_rdata[l]);
      check_output({tag, "_resp_err"}, 64'(resp_err), 64'(e_err[l]));
      if (resp_ready) pend[l] = 1'b0;
    end
    if (was_idle && req_valid) begin
      pend[l]    = 1'b1;
      done[l]    = 1'b0;
      acc[l]     = cyc;
      p_addr[l]  = req_addr;
      p_wen[l]   = req_wen;
      p_wdata[l] = req_wdata;
      p_wmask[l] = req_wmask;
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      check_lane(0, bus_a.req_valid, bus_a.req_ready, bus_a.req_addr, bus_a.req_wen,
                 bus_a.req_wdata, bus_a.req_wmask, bus_a.resp_valid, bus_a.resp_ready,
                 bus_a.resp_rdata, bus_a.resp_err);
      check_lane(1, bus_b.req_valid, bus_b.req_ready, bus_b.req_addr, bus_b.req_wen,
                 bus_b.req_wdata, bus_b.req_wmask, bus_b.resp_valid, bus_b.resp_ready,
                 bus_b.resp_rdata, bus_b.resp_err);
    end
  end

  function automatic logic rdy(int l);
    return (l == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction
  function automatic logic rvalid(int l);
    return (l == 0) ? bus_a.resp_valid : bus_b.resp_valid;
  endfunction
  function automatic logic [63:0] rdata_of(int l);
    return (l == 0) ? bus_a.resp_rdata : bus_b.resp_rdata;
  endfunction
  function automatic logic err_of(int l);
    return (l == 0) ? bus_a.resp_err : bus_b.resp_err;
  endfunction

  task automatic drive_req(int l, logic v, logic [63:0] addr, logic wen, logic [63:0] wdata,
                           logic [7:0] wmask);
    if (l == 0) begin
      bus_a.req_valid = v; bus_a.req_addr = addr; bus_a.req_wen = wen;
      bus_a.req_wdata = wdata; bus_a.req_wmask = wmask;
    end else begin
      bus_b.req_valid = v; bus_b.req_addr = addr; bus_b.req_wen = wen;
      bus_b.req_wdata = wdata; bus_b.req_wmask = wmask;
    end
  endtask

  task automatic wait_accept(int l);
    int n;
    n = 0;
    @(negedge clock);
    while (!rdy(l) && n < 50) begin
      n++;
      @(negedge clock);
    end
    check_output("accept_timeout", 64'(rdy(l)), 64'd1);
    @(posedge clock); #1;
    drive_req(l, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
  endtask

  task automatic wait_resp(int l, output logic [63:0] rd, output logic er, output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!rvalid(l) && k < 60);
    check_output("resp_timeout", 64'(rvalid(l)), 64'd1);
    rd = rdata_of(l);
    er = err_of(l);
    @(posedge clock); #1;
  endtask

  task automatic apply_stimulus(int l, logic [63:0] addr, logic wen, logic [63:0] wdata,
                                logic [7:0] wmask, output logic [63:0] rd, output logic er,
                                output int k);
    drive_req(l, 1'b1, addr, wen, wdata, wmask);
    wait_accept(l);
    wait_resp(l, rd, er, k);
  endtask

  task automatic check_reset_vals(string tag);
    check_output({tag, "_a_req_ready"},  64'(bus_a.req_ready),  64'd1);
    check_output({tag, "_a_resp_valid"}, 64'(bus_a.resp_valid), 64'd0);
    check_output({tag, "_a_resp_rdata"}, bus_a.resp_rdata,      64'd0);
    check_output({tag, "_a_resp_err"},   64'(bus_a.resp_err),   64'd0);
    check_output({tag, "_b_req_ready"},  64'(bus_b.req_ready),  64'd1);
    check_output({tag, "_b_resp_valid"}, 64'(bus_b.resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          k;
    int          last;
    int          nacc;

    drive_req(0, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
    drive_req(1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
    bus_a.resp_ready = 1'b1;
    bus_b.resp_ready = 1'b1;
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check_reset_vals("post_reset");

    $display("[TB] full-word store, latency and readback");
    apply_stimulus(0, BASE, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, rd, er, k);
    apply_stimulus(0, BASE + SPAN - 64'd8, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, k);
    apply_stimulus(0, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, rd, er, k);
    check_output("store_latency", 64'(k), 64'd4);
    check_output("store_rdata", rd, 64'd0);
    check_output("store_err", 64'(er), 64'd0);
    apply_stimulus(0, 64'h8000_0010, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("load_full", rd, 64'h1122_3344_5566_7788);
    check_output("load_latency", 64'(k), 64'd4);

    $display("[TB] partial and empty byte masks");
    apply_stimulus(0, 64'h8000_0010, 1'b1, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, rd, er, k);
    apply_stimulus(0, 64'h8000_0010, 1'b0, 64'd0, 8'hFF, rd, er, k);
    check_output("load_partial", rd, 64'h1122_3344_BBBB_BBBB);
    apply_stimulus(0, 64'h8000_0010, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, k);
    check_output("mask0_err", 64'(er), 64'd0);
    apply_stimulus(0, 64'h8000_0010, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("mask0_unchanged", rd, 64'h1122_3344_BBBB_BBBB);

    $display("[TB] out-of-range accesses");
    apply_stimulus(0, 64'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("below_err", 64'(er), 64'd1);
    check_output("below_rdata", rd, 64'd0);
    apply_stimulus(0, BASE + SPAN, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("above_err", 64'(er), 64'd1);
    check_output("above_rdata", rd, 64'd0);
    apply_stimulus(0, 64'h7FFF_FFF8, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, rd, er, k);
    check_output("below_store_err", 64'(er), 64'd1);
    apply_stimulus(0, BASE + SPAN, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, rd, er, k);
    check_output("above_store_err", 64'(er), 64'd1);
    apply_stimulus(0, BASE, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("word0_intact", rd, 64'hDEAD_BEEF_CAFE_F00D);
    apply_stimulus(0, BASE + SPAN - 64'd8, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("last_word_intact", rd, 64'h0123_4567_89AB_CDEF);
    check_output("last_word_err", 64'(er), 64'd0);

    $display("[TB] response back-pressure");
    bus_a.resp_ready = 1'b0;
    apply_stimulus(0, 64'h8000_0010, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("hold_first_rdata", rd, 64'h1122_3344_BBBB_BBBB);
    drive_req(0, 1'b1, BASE, 1'b0, 64'd0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_output("hold_resp_valid", 64'(rvalid(0)), 64'd1);
      check_output("hold_req_ready", 64'(rdy(0)), 64'd0);
      check_output("hold_rdata", rdata_of(0), 64'h1122_3344_BBBB_BBBB);
      check_output("hold_err", 64'(err_of(0)), 64'd0);
    end
    @(posedge clock); #1;
    bus_a.resp_ready = 1'b1;
    @(negedge clock);
    check_output("handshake_req_ready", 64'(rdy(0)), 64'd0);
    @(negedge clock);
    check_output("after_handshake_req_ready", 64'(rdy(0)), 64'd1);
    @(posedge clock); #1;
    drive_req(0, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
    wait_resp(0, rd, er, k);
    check_output("second_req_rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);
    check_output("second_req_latency", 64'(k), 64'd4);

    $display("[TB] reset during wait");
    drive_req(0, 1'b1, 64'h8000_0010, 1'b1, 64'h5555_5555_5555_5555, 8'hFF);
    wait_accept(0);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    apply_stimulus(0, 64'h8000_0010, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("abort_old_data", rd, 64'h1122_3344_BBBB_BBBB);

    $display("[TB] zero-latency instance");
    apply_stimulus(1, BASE, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, rd, er, k);
    check_output("b_store_latency", 64'(k), 64'd2);
    apply_stimulus(1, BASE + 64'd8, 1'b1, 64'hA5A5_0000_FFFF_1234, 8'hFF, rd, er, k);
    apply_stimulus(1, BASE + 64'd8, 1'b0, 64'd0, 8'h00, rd, er, k);
    check_output("b_load_rdata", rd, 64'hA5A5_0000_FFFF_1234);
    check_output("b_load_latency", 64'(k), 64'd2);
    drive_req(1, 1'b1, BASE + 64'd8, 1'b0, 64'd0, 8'h00);
    last = -1;
    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (rdy(1)) begin
        if (last >= 0) check_output("b2b_interval", 64'(i - last), 64'd3);
        last = i;
        nacc++;
      end
    end
    @(posedge clock); #1;
    drive_req(1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
    check_output("b2b_accepts", 64'(nacc), 64'd6);
    repeat (4) @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Memory-side responder: the target end of the LSU load/store interface. It services one request at a time from the LSU over a valid/ready channel.
- Backed by an on-chip 64-bit word array with byte-masked writes and a programmable response latency.
- Replaces DPI-based pmem access for synthesizable and simulation-agnostic runs. Sits between the LSU and the data memory map.

Parameters:
- DEPTH, 4096, number of 64-bit words in the array (power of two).
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- LATENCY, 2, extra wait cycles before the access commits (0..15).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  64  byte address; bits [2:0] ignored (word aligned).
- req_wen  input  1  1 = store, 0 = load.
- req_wdata  input  64  store data, byte lanes aligned to the word.
- req_wmask  input  8  byte strobes; bit i enables byte lane i.
- resp_valid  output  1  response present.
- resp_ready  input  1  LSU accepts the response.
- resp_rdata  output  64  load data; 0 for stores and errors.
- resp_err  output  1  address outside [BASE_ADDR, BASE_ADDR+DEPTH*8).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clock and reset.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0. Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch addr/wen/wdata/wmask, load cnt=LATENCY, go to WAIT.
  - WAIT: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access this edge and go to RESP.
  - RESP: resp_valid=1; resp_rdata/resp_err are held stable until resp_ready. On resp_valid&&resp_ready go to IDLE.
- Latency: request accepted at edge T; resp_valid rises after edge T+1+LATENCY. Minimum round trip is 2 cycles at LATENCY=0.
- Back-to-back: a new request can be accepted the cycle after the response handshake, never in the same cycle (req_ready=0 in RESP). Throughput is 1 request per LATENCY+3 cycles with resp_ready held high.
- Access at commit:
  - Index = (addr-BASE_ADDR)>>3.
  - In range, store: byte i of word written iff wmask[i]; rdata=0.
  - In range, load: rdata = full word; wmask ignored.
  - Out of range: no array change; rdata=0; err=1.
- Ordering: a store commits before its response, so any later load observes it.
- Edge cases:
  - wmask=0 store: no change, normal response, err=0.
  - req_valid with req_ready=0: ignored; the LSU must hold the request.
  - resp_ready held low: stays in RESP indefinitely, outputs stable.
  - Reset mid-operation (WAIT or RESP): aborts to IDLE immediately. A store still in WAIT with cnt!=0 is not committed. A store whose commit edge has passed remains committed.
  - Address arithmetic is unsigned 64-bit. Addresses below BASE_ADDR fail the range check and do not wrap into the array.

Decomposition:
- Shared package (lsu_pkg):
  - state enum {IDLE, WAIT, RESP};
  - default BASE_ADDR constant;
  - byte-mask width constant (8);
  - request struct {addr, wen, wdata, wmask}.
- Sub-module pmem_array: single-port DEPTH x 64 synchronous array with an 8-bit byte write enable and registered read data, instantiated once. The FSM drives its enable at the WAIT->RESP commit edge.

Test Plan:
- Reset release, LATENCY=2: store addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF -> resp_valid rises at edge T+3, rdata=0, err=0. Then load 0x8000_0010 -> rdata 0x1122334455667788.
- Partial store wmask 0x0F, wdata 0xAAAAAAAA_BBBBBBBB over the word above -> subsequent load returns 0x11223344_BBBBBBBB.
- Load at 0x7FFF_FFF8 and at BASE+DEPTH*8 -> err=1, rdata=0, and no array change (confirmed by a re-read of word 0).
- resp_ready held low 10 cycles with req_valid asserted -> resp_valid, rdata and err stable; req_ready=0; the second request is accepted only the cycle after the handshake.
- Store issued, reset asserted asynchronously during WAIT with cnt=1 -> outputs at reset values immediately; a later load shows the old data.
- LATENCY=0 build: back-to-back loads with resp_ready=1 -> each response appears 2 cycles after acceptance; the request-to-request interval is 3 cycles.
